clock_set_ctrl: RTL and testbench

Run/set controller for the 24-hour HH:MM:SS time-of-day counter. It derives the once-per-second advance from the system clock and steps a mode state machine driven by two front-panel button pulses. In the set states it freezes timekeeping and lets the user increment the hour, minute or second field individually. It sits between the debounced button logic and the display driver, and owns the time registers.

---
 rtl/clock_pkg.sv | 18 +
 rtl/clock_set_ctrl_if.sv | 24 ++
 rtl/hms_counter.sv | 45 ++++
 rtl/clock_set_ctrl.sv | 87 ++++++++
 tb/tb_clock_set_ctrl.sv | 174 +++++++++++++++++
 5 files changed

// File: rtl/clock_pkg.sv
// Shared types and limits for the HH:MM:SS run/set clock.
// Mode encoding, field widths and wrap values.
package clock_pkg;

  localparam int H_W  = 5;
  localparam int MS_W = 6;

  localparam logic [H_W-1:0]  HOUR_MAX    = 5'd23;
  localparam logic [MS_W-1:0] MIN_SEC_MAX = 6'd59;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SET_H = 2'd1,
    SET_M = 2'd2,
    SET_S = 2'd3
  } mode_t;

endpackage

// File: rtl/clock_set_ctrl_if.sv
// Panel/display bundle: button pulses in, time fields, mode and tick out.
// slave = controller side, master = panel/display side.
interface clock_set_ctrl_if;
  import clock_pkg::*;

  logic             btn_mode;
  logic             btn_inc;
  logic [H_W-1:0]   H_reg;
  logic [MS_W-1:0]  M_reg;
  logic [MS_W-1:0]  S_reg;
  mode_t            mode;
  logic             sec_tick;

  modport slave (
    input  btn_mode, btn_inc,
    output H_reg, M_reg, S_reg, mode, sec_tick
  );

  modport master (
    output btn_mode, btn_inc,
    input  H_reg, M_reg, S_reg, mode, sec_tick
  );

endinterface

// File: rtl/hms_counter.sv
// Time-of-day registers: cascaded advance or single-field increments.
// Ports: adv, inc_h/inc_m/inc_s in; h, m, s out.
module hms_counter
  import clock_pkg::*;
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            adv,
  input  logic            inc_h,
  input  logic            inc_m,
  input  logic            inc_s,
  output logic [H_W-1:0]  h,
  output logic [MS_W-1:0] m,
  output logic [MS_W-1:0] s
);

  logic h_top, m_top, s_top;
  logic [H_W-1:0]  h_nx;
  logic [MS_W-1:0] m_nx, s_nx;

  assign h_top = (h == HOUR_MAX);
  assign m_top = (m == MIN_SEC_MAX);
  assign s_top = (s == MIN_SEC_MAX);

  assign h_nx = h_top ? '0 : h + H_W'(1);
  assign m_nx = m_top ? '0 : m + MS_W'(1);
  assign s_nx = s_top ? '0 : s + MS_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h <= '0;
      m <= '0;
      s <= '0;
    end else if (adv) begin
      s <= s_nx;
      if (s_top) m <= m_nx;
      if (s_top && m_top) h <= h_nx;
    end else begin
      if (inc_h) h <= h_nx;
      if (inc_m) m <= m_nx;
      if (inc_s) s <= s_nx;
    end
  end

endmodule

// File: rtl/clock_set_ctrl.sv
// Run/set controller: second prescaler, mode FSM, time registers.
// Ports: clk, rst_n, bus (buttons in; H/M/S, mode, sec_tick out).
module clock_set_ctrl
  import clock_pkg::*;
#(
  parameter int TICK_DIV = 50_000_000
)(
  input  logic             clk,
  input  logic             rst_n,
  clock_set_ctrl_if.slave  bus
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] P_LAST = PW'(TICK_DIV - 1);

  mode_t         state, state_nx;
  logic [PW-1:0] presc, presc_nx;
  logic          tick, tick_nx;
  logic          inc, adv, inc_h, inc_m, inc_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= RUN;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (bus.btn_mode) begin
      unique case (state)
        RUN:   state_nx = SET_H;
        SET_H: state_nx = SET_M;
        SET_M: state_nx = SET_S;
        SET_S: state_nx = RUN;
      endcase
    end
  end

  // btn_mode has priority; a coincident btn_inc is dropped.
  always_comb begin
    inc   = bus.btn_inc && !bus.btn_mode;
    inc_h = 1'b0;
    inc_m = 1'b0;
    inc_s = 1'b0;
    unique case (1'b1)
      (state == SET_H): inc_h = inc;
      (state == SET_M): inc_m = inc;
      (state == SET_S): inc_s = inc;
      default: ;
    endcase
    adv = tick;
  end

  // Prescaler only runs while staying in RUN, so entering RUN
  // starts a full TICK_DIV period from 0.
  always_comb begin
    presc_nx = '0;
    if (state == RUN && state_nx == RUN)
      presc_nx = (presc == P_LAST) ? '0 : presc + PW'(1);
    tick_nx = (state_nx == RUN) && (presc_nx == P_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_nx;
      tick  <= tick_nx;
    end
  end

  hms_counter u_hms (
    .clk   (clk),
    .rst_n (rst_n),
    .adv   (adv),
    .inc_h (inc_h),
    .inc_m (inc_m),
    .inc_s (inc_s),
    .h     (bus.H_reg),
    .m     (bus.M_reg),
    .s     (bus.S_reg)
  );

  assign bus.mode     = state;
  assign bus.sec_tick = tick;

endmodule

// File: tb/tb_clock_set_ctrl.sv
// Directed bench for clock_set_ctrl with TICK_DIV=4.
// Inputs driven and outputs sampled on the falling edge.
module tb_clock_set_ctrl;
  import clock_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  clock_set_ctrl_if bus ();

  clock_set_ctrl #(.TICK_DIV(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int bad_tick = 0;

  always @(negedge clk)
    if (rst_n && bus.mode != RUN && bus.sec_tick)
      bad_tick++;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  task automatic chk_time(input string tag, input int h,
                          input int m, input int s);
    chk({tag, "_h"}, int'(bus.H_reg), h);
    chk({tag, "_m"}, int'(bus.M_reg), m);
    chk({tag, "_s"}, int'(bus.S_reg), s);
  endtask

  task automatic pulse_mode(input int n);
    bus.btn_mode = 1'b1;
    repeat (n) @(negedge clk);
    bus.btn_mode = 1'b0;
  endtask

  task automatic inc(input int n);
    bus.btn_inc = 1'b1;
    repeat (n) @(negedge clk);
    bus.btn_inc = 1'b0;
  endtask

  task automatic wait_tick(output int k);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.sec_tick && k < 20);
  endtask

  int k, nt, first, gap_err, glitch, eh, em, es, ticks_at;

  initial begin
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;

    // reset state and free run
    repeat (2) @(negedge clk);
    chk_time("rst", 0, 0, 0);
    chk("rst_mode", int'(bus.mode), 0);
    chk("rst_tick", int'(bus.sec_tick), 0);
    rst_n = 1'b1;
    nt = 0; first = -1; gap_err = 0; ticks_at = 0;
    for (int i = 1; i <= 240; i++) begin
      @(negedge clk);
      if (bus.sec_tick) begin
        if (first < 0) first = i;
        else if (i - ticks_at != 4) gap_err++;
        ticks_at = i;
        nt++;
      end
    end
    chk("run_ticks", nt, 60);
    chk("run_first", first, 3);
    chk("run_gap", gap_err, 0);
    chk_time("run240", 0, 1, 0);
    chk("run_mode", int'(bus.mode), 0);

    // full-day wrap: set 23:59:58 from a fresh reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    pulse_mode(1);
    inc(23);
    pulse_mode(1);
    inc(59);
    pulse_mode(1);
    inc(58);
    chk_time("preset", 23, 59, 58);
    pulse_mode(1);
    glitch = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i < 4) begin eh = 23; em = 59; es = 58; end
      else if (i < 8) begin eh = 23; em = 59; es = 59; end
      else begin eh = 0; em = 0; es = 0; end
      if (int'(bus.H_reg) != eh || int'(bus.M_reg) != em ||
          int'(bus.S_reg) != es) glitch++;
      if (bus.sec_tick != (i == 3 || i == 7)) glitch++;
      if (i == 4) chk_time("wrap59", 23, 59, 59);
    end
    chk_time("wrap00", 0, 0, 0);
    chk("wrap_glitch", glitch, 0);

    // set hours with wrap
    pulse_mode(1);
    inc(25);
    chk("seth_mode", int'(bus.mode), 1);
    chk_time("seth", 1, 0, 0);

    // set seconds without carry, then back to RUN
    pulse_mode(1);
    inc(7);
    pulse_mode(1);
    inc(59);
    chk("sets_59", int'(bus.S_reg), 59);
    inc(1);
    chk_time("sets_nocarry", 1, 7, 0);
    pulse_mode(1);
    chk("torun_mode", int'(bus.mode), 0);
    wait_tick(k);
    chk("torun_first", k, 3);

    // btn_mode coincident with sec_tick: advance plus SET_H
    pulse_mode(1);
    chk("coinc_mode", int'(bus.mode), 1);
    chk_time("coinc", 1, 7, 1);

    // simultaneous buttons in SET_M
    pulse_mode(1);
    bus.btn_mode = 1'b1;
    bus.btn_inc  = 1'b1;
    @(negedge clk);
    bus.btn_mode = 1'b0;
    bus.btn_inc  = 1'b0;
    chk("both_mode", int'(bus.mode), 3);
    chk("both_m", int'(bus.M_reg), 7);

    // reach SET_H at 05:17:30, then async reset
    inc(29);
    pulse_mode(2);
    inc(4);
    pulse_mode(1);
    inc(10);
    pulse_mode(3);
    chk("pre_rst_mode", int'(bus.mode), 1);
    chk_time("pre_rst", 5, 17, 30);
    #2;
    rst_n = 1'b0;
    #1;
    chk_time("async_rst", 0, 0, 0);
    chk("async_mode", int'(bus.mode), 0);
    chk("async_tick", int'(bus.sec_tick), 0);
    chk("set_no_tick", bad_tick, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
